// File: rtl/cnn_row_streamer.sv
// ----------------------------------------------------------------------------
// cnn_row_streamer
//
// Holds one IMG_H x IMG_W frame written by a host and streams it row-major
// into the cnn pixel input. After a start pulse the first PRIME_ROWS rows go
// out back-to-back. After that, one more row is released for each rising edge
// of the cnn's o_intr. Every row group is followed by exactly one idle cycle.
//
// Ports
//   axi_clk        clock, all logic on the rising edge
//   axi_rst        synchronous active-high reset (frame buffer is kept)
//   i_wr_en        frame buffer write strobe (honoured only while idle)
//   i_wr_addr      write address, pixel (r,c) lives at r*IMG_W+c
//   i_wr_data      write pixel
//   i_start        single-cycle pulse, starts streaming one frame
//   i_intr         cnn o_intr, a rising edge requests the next row
//   o_data_valid   pixel valid towards cnn i_data_valid
//   o_data         pixel towards cnn i_data (holds its value while invalid)
//   o_busy         high from the accepted start until o_done
//   o_done         one-cycle pulse after the last pixel of the frame
//   o_intr_ovf     sticky, a row request was dropped
// ----------------------------------------------------------------------------
module cnn_row_streamer #(
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int PIX_W      = 8,
    parameter int PRIME_ROWS = 4,
    parameter int ADDR_W     = 10
) (
    input  logic              axi_clk,
    input  logic              axi_rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [PIX_W-1:0]  i_wr_data,
    input  logic              i_start,
    input  logic              i_intr,
    output logic              o_data_valid,
    output logic [PIX_W-1:0]  o_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_intr_ovf
);

    localparam int DEPTH = IMG_W * IMG_H;
    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW    = $clog2(IMG_H + 1);

    localparam logic [CW-1:0]     COL_LAST     = CW'(IMG_W - 1);
    localparam logic [RW-1:0]     ROW_COUNT    = RW'(IMG_H);
    localparam logic [RW-1:0]     PRIME_LAST   = RW'(PRIME_ROWS - 1);
    localparam logic [RW:0]       PRIME_COMMIT = (RW + 1)'(PRIME_ROWS);
    localparam logic [RW:0]       ROW_LIMIT    = (RW + 1)'(IMG_H);
    localparam logic [ADDR_W:0]   DEPTH_A      = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        GAP,
        WAIT,
        ROW,
        FIN
    } state_t;

    state_t            state;
    logic [PIX_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] rd_addr;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic              pending;
    logic              intr_q;
    logic [PIX_W-1:0]  ram_q;
    logic              ram_vld;

    logic              issuing;
    logic              row_end;
    logic              intr_rise;
    logic              wr_ok;
    logic [RW:0]       committed;
    logic              req_ok;

    assign issuing   = (state == PRIME) || (state == ROW);
    assign row_end   = issuing && (col == COL_LAST);
    assign intr_rise = i_intr && !intr_q;
    assign wr_ok     = (state == IDLE) && i_wr_en && ({1'b0, i_wr_addr} < DEPTH_A);

    // Rows already committed to the stream: the prime block as a whole, the
    // row currently being read, or the rows finished so far while between
    // groups. A request is only worth keeping if committed rows plus the
    // queued one still leave a row of the frame unsent.
    always_comb begin
        committed = {1'b0, row};
        case (state)
            PRIME:   committed = PRIME_COMMIT;
            ROW:     committed = {1'b0, row} + (RW + 1)'(1);
            default: committed = {1'b0, row};
        endcase
        req_ok = (committed + {{RW{1'b0}}, pending}) < ROW_LIMIT;
    end

    // Frame buffer. Reads and writes never collide because writes are only
    // taken while idle and reads only happen while streaming.
    always_ff @(posedge axi_clk) begin
        if (wr_ok) begin
            mem[i_wr_addr] <= i_wr_data;
        end
        if (issuing) begin
            ram_q <= mem[rd_addr];
        end
    end

    // Sequencer: address generation, the row release handshake and the
    // two-stage output pipeline (RAM read register, then output register).
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            state        <= IDLE;
            rd_addr      <= '0;
            col          <= '0;
            row          <= '0;
            pending      <= 1'b0;
            intr_q       <= 1'b0;
            ram_vld      <= 1'b0;
            o_data_valid <= 1'b0;
            o_data       <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_intr_ovf   <= 1'b0;
        end else begin
            intr_q       <= i_intr;
            ram_vld      <= issuing;
            o_data_valid <= ram_vld;
            o_done       <= 1'b0;
            if (ram_vld) begin
                o_data <= ram_q;
            end

            // Address advances linearly, row/column tracked alongside so
            // the row boundary is known without a multiply.
            if (issuing) begin
                rd_addr <= rd_addr + ADDR_W'(1);
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (i_start) begin
                        state      <= PRIME;
                        o_busy     <= 1'b1;
                        o_intr_ovf <= 1'b0;
                        rd_addr    <= '0;
                        col        <= '0;
                        row        <= '0;
                        pending    <= 1'b0;
                    end
                end

                PRIME, ROW: begin
                    if (intr_rise && req_ok) begin
                        if (pending) begin
                            o_intr_ovf <= 1'b1;
                        end else begin
                            pending <= 1'b1;
                        end
                    end
                    if (row_end && (state == ROW || row == PRIME_LAST)) begin
                        state <= GAP;
                    end
                end

                // The queued request is consumed here; a new edge in the same
                // cycle re-arms it rather than counting as an overflow.
                GAP: begin
                    if (row == ROW_COUNT) begin
                        state <= FIN;
                    end else if (pending) begin
                        state   <= ROW;
                        pending <= intr_rise && req_ok;
                    end else begin
                        state <= WAIT;
                        if (intr_rise && req_ok) begin
                            pending <= 1'b1;
                        end
                    end
                end

                WAIT: begin
                    if (pending || intr_rise) begin
                        state   <= ROW;
                        pending <= pending && intr_rise && req_ok;
                    end
                end

                FIN: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_row_streamer.sv
// ----------------------------------------------------------------------------
// tb_cnn_row_streamer
//
// Bench for cnn_row_streamer. A frame-level model predicts every output on
// every cycle (pixels issued per row group, one idle cycle between groups,
// grants counted in whole rows), and directed phases pin a few literal
// values. The last phase drives random pixel data, intr pulses and writes.
// ----------------------------------------------------------------------------
module tb_cnn_row_streamer;

    localparam int IMG_W      = 28;
    localparam int IMG_H      = 28;
    localparam int PIX_W      = 8;
    localparam int PRIME_ROWS = 4;
    localparam int ADDR_W     = 10;
    localparam int DEPTH      = IMG_W * IMG_H;

    logic              axi_clk = 1'b0;
    logic              axi_rst = 1'b0;
    logic              i_wr_en = 1'b0;
    logic [ADDR_W-1:0] i_wr_addr = '0;
    logic [PIX_W-1:0]  i_wr_data = '0;
    logic              i_start = 1'b0;
    logic              i_intr = 1'b0;
    logic              o_data_valid;
    logic [PIX_W-1:0]  o_data;
    logic              o_busy;
    logic              o_done;
    logic              o_intr_ovf;

    cnn_row_streamer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W),
        .PRIME_ROWS(PRIME_ROWS), .ADDR_W(ADDR_W)
    ) dut (
        .axi_clk(axi_clk), .axi_rst(axi_rst),
        .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .i_start(i_start), .i_intr(i_intr),
        .o_data_valid(o_data_valid), .o_data(o_data),
        .o_busy(o_busy), .o_done(o_done), .o_intr_ovf(o_intr_ovf)
    );

    always #5 axi_clk = ~axi_clk;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int beat_total = 0;
    int done_total = 0;
    bit compare_on = 1'b0;
    logic [PIX_W-1:0] beat_log[$];
    int beat_cycle[$];

    // ---------------- frame-level reference model ----------------
    typedef enum {M_IDLE, M_STREAM, M_DRAIN, M_WAITING, M_FINISH} phase_t;

    logic [PIX_W-1:0] shadow [DEPTH];
    phase_t           phase = M_IDLE;
    bit               m_active, m_done, m_ovf, m_valid, s1_valid, prev_intr;
    logic [PIX_W-1:0] m_data = '0;
    logic [PIX_W-1:0] s1_data = '0;
    int               next_pix, group_end, granted;

    // A rise asks for one more row; at most one row may be granted beyond
    // those already committed, and never beyond the frame.
    task automatic request(input bit rise);
        if (rise) begin
            if (granted >= IMG_H) begin
            end else if (granted > group_end / IMG_W) begin
                m_ovf = 1'b1;
            end else begin
                granted++;
            end
        end
    endtask

    task automatic start_row_if_granted();
        if (granted > group_end / IMG_W) begin
            group_end += IMG_W;
            phase = M_STREAM;
        end
    endtask

    always @(posedge axi_clk) begin
        bit rise;
        bit issue;
        logic [PIX_W-1:0] issue_data;
        rise = i_intr && !prev_intr;
        issue = 1'b0;
        issue_data = '0;
        if (axi_rst) begin
            m_active = 0; m_done = 0; m_ovf = 0; m_valid = 0; m_data = '0;
            s1_valid = 0; prev_intr = 0; phase = M_IDLE;
            granted = 0; group_end = 0; next_pix = 0;
        end else begin
            prev_intr = i_intr;
            if (!m_active && i_wr_en && int'(i_wr_addr) < DEPTH) begin
                shadow[i_wr_addr] = i_wr_data;
            end
            m_done = 1'b0;
            case (phase)
                M_IDLE: if (i_start) begin
                    m_active = 1; m_ovf = 0; next_pix = 0;
                    granted = PRIME_ROWS; group_end = PRIME_ROWS * IMG_W;
                    phase = M_STREAM;
                end
                M_STREAM: begin
                    issue = 1'b1;
                    issue_data = shadow[next_pix];
                    next_pix++;
                    request(rise);
                    if (next_pix == group_end) phase = M_DRAIN;
                end
                M_DRAIN: begin
                    if (group_end == DEPTH) begin
                        phase = M_FINISH;
                    end else begin
                        start_row_if_granted();
                        if (phase == M_DRAIN) phase = M_WAITING;
                        request(rise);
                    end
                end
                M_WAITING: begin
                    if (granted > group_end / IMG_W) begin
                        start_row_if_granted();
                        request(rise);
                    end else begin
                        request(rise);
                        start_row_if_granted();
                    end
                end
                M_FINISH: begin
                    m_active = 0; m_done = 1; phase = M_IDLE;
                end
                default: phase = M_IDLE;
            endcase
            m_valid = s1_valid;
            if (s1_valid) m_data = s1_data;
            s1_valid = issue;
            s1_data = issue_data;
        end
    end

    // ---------------- checking ----------------
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
        end
    endtask

    always @(posedge axi_clk) begin
        #1;
        cycle++;
        if (o_data_valid === 1'b1) begin
            beat_total++;
            beat_log.push_back(o_data);
            beat_cycle.push_back(cycle);
        end
        if (o_done === 1'b1) done_total++;
        if (compare_on) begin
            checkOutput("o_data_valid", 32'(o_data_valid), 32'(m_valid));
            checkOutput("o_data", 32'(o_data), 32'(m_data));
            checkOutput("o_busy", 32'(o_busy), 32'(m_active));
            checkOutput("o_done", 32'(o_done), 32'(m_done));
            checkOutput("o_intr_ovf", 32'(o_intr_ovf), 32'(m_ovf));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge axi_clk);
    endtask

    task automatic write_pixel(input int addr, input int data);
        i_wr_en = 1'b1;
        i_wr_addr = ADDR_W'(addr);
        i_wr_data = PIX_W'(data);
        tick(1);
        i_wr_en = 1'b0;
    endtask

    task automatic start_frame();
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
    endtask

    task automatic pulse_intr(input int width);
        i_intr = 1'b1;
        tick(width);
        i_intr = 1'b0;
        tick(1);
    endtask

    task automatic reset_cycle();
        axi_rst = 1'b1;
        tick(1);
        axi_rst = 1'b0;
    endtask

    task automatic wait_beats(input int target, input int budget);
        int n = 0;
        while (beat_total < target && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput("beat wait", 32'(beat_total), 32'(target));
    endtask

    task automatic finish_frame();
        int d0 = done_total;
        for (int i = 0; i < 30 && done_total == d0; i++) begin
            pulse_intr(2);
            tick(40);
        end
        checkOutput("frame completes", 32'(done_total - d0), 32'd1);
    endtask

    // One random action: idle time, an intr pulse, or a write attempt.
    task automatic applyStimulus();
        int r = $urandom_range(0, 9);
        if (r < 5) tick($urandom_range(1, 30));
        else if (r < 9) pulse_intr($urandom_range(1, 4));
        else write_pixel($urandom_range(0, DEPTH + 20), $urandom_range(0, 255));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int base, sc, pc, b, d0;

        axi_rst = 1'b1;
        tick(2);
        compare_on = 1'b1;
        tick(1);
        axi_rst = 1'b0;
        checkOutput("reset valid", 32'(o_data_valid), 32'd0);
        checkOutput("reset busy", 32'(o_busy), 32'd0);
        checkOutput("reset done", 32'(o_done), 32'd0);
        checkOutput("reset ovf", 32'(o_intr_ovf), 32'd0);
        checkOutput("reset data", 32'(o_data), 32'd0);

        for (int a = 0; a < DEPTH; a++) write_pixel(a, a % 256);

        // Prime block: 112 beats, first two cycles after start.
        base = beat_total;
        start_frame();
        sc = cycle;
        tick(140);
        checkOutput("prime beat count", 32'(beat_total - base), 32'd112);
        checkOutput("prime first pixel", 32'(beat_log[base]), 32'h00);
        checkOutput("prime last pixel", 32'(beat_log[base + 111]), 32'h6F);
        checkOutput("prime latency", 32'(beat_cycle[base] - sc), 32'd2);
        checkOutput("busy while waiting", 32'(o_busy), 32'd1);

        // Remaining 24 rows, one per intr edge.
        d0 = done_total;
        i_intr = 1'b1;
        tick(1);
        pc = cycle;
        tick(1);
        i_intr = 1'b0;
        tick(40);
        checkOutput("row latency", 32'(beat_cycle[base + 112] - pc), 32'd2);
        checkOutput("row pixel", 32'(beat_log[base + 112]), 32'd112);
        for (int i = 1; i < 24; i++) begin
            pulse_intr(2);
            tick(40);
        end
        checkOutput("frame beats", 32'(beat_total - base), 32'd784);
        checkOutput("frame done pulses", 32'(done_total - d0), 32'd1);
        checkOutput("busy after done", 32'(o_busy), 32'd0);

        // Intr held high for 10 cycles releases a single row.
        start_frame();
        tick(130);
        b = beat_total;
        i_intr = 1'b1;
        tick(10);
        i_intr = 1'b0;
        tick(50);
        checkOutput("held intr rows", 32'(beat_total - b), 32'd28);
        reset_cycle();

        // Two edges inside one row: one served, one dropped.
        b = beat_total;
        start_frame();
        tick(130);
        pulse_intr(1);
        tick(4);
        pulse_intr(1);
        tick(3);
        pulse_intr(1);
        tick(100);
        checkOutput("ovf after drop", 32'(o_intr_ovf), 32'd1);
        checkOutput("served rows", 32'(beat_total - b), 32'd168);
        finish_frame();
        checkOutput("ovf sticky", 32'(o_intr_ovf), 32'd1);
        start_frame();
        checkOutput("ovf cleared by start", 32'(o_intr_ovf), 32'd0);
        reset_cycle();

        // Reset in the middle of the prime block.
        b = beat_total;
        start_frame();
        wait_beats(b + 50, 100);
        reset_cycle();
        checkOutput("mid reset valid", 32'(o_data_valid), 32'd0);
        checkOutput("mid reset data", 32'(o_data), 32'd0);
        checkOutput("mid reset busy", 32'(o_busy), 32'd0);
        b = beat_total;
        start_frame();
        tick(3);
        checkOutput("replay pixel0", 32'(beat_log[b]), 32'd0);

        // Write while busy is ignored; after idle it lands; 800 is out of range.
        write_pixel(5, 8'hAA);
        tick(10);
        checkOutput("busy write ignored", 32'(beat_log[b + 5]), 32'd5);
        reset_cycle();
        write_pixel(5, 8'hAA);
        write_pixel(800, 8'h55);
        b = beat_total;
        start_frame();
        tick(25);
        checkOutput("idle write lands", 32'(beat_log[b + 5]), 32'hAA);
        checkOutput("out of range write", 32'(beat_log[b + 16]), 32'd16);
        reset_cycle();

        // Randomised frames.
        for (int a = 0; a < DEPTH; a++) write_pixel(a, $urandom_range(0, 255));
        for (int f = 0; f < 3; f++) begin
            pulse_intr(1);
            start_frame();
            for (int k = 0; k < 60; k++) applyStimulus();
            finish_frame();
            for (int k = 0; k < 5; k++) write_pixel($urandom_range(0, DEPTH - 1), $urandom_range(0, 255));
        end

        tick(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d expected end", cycle);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
